// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI-slave register bank feeding the SPI peripheral mux
//
// Decodes 32-bit MSB-first frames (write flag, 7-bit address, 24-bit data)
// framed by cs2, with all SPI pins oversampled in the clk domain.
//
// Ports:
//   clk          system clock, the only clock
//   rst          synchronous active-high reset
//   cs2          register-bank chip select, active low
//   spi_clk      MCU SPI clock (mode 0), asynchronous to clk
//   spi_mosi     MCU serial data, MSB first
//   status       read-only status word, sampled when read data is loaded
//   dout         serial read data towards the mux
//   reg_spi_mux  peripheral select vector
//   reg_led      general control register
module spi_reg_bank #(
  parameter logic [23:0] MAGIC = 24'hA5_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs2,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  input  logic [23:0] status,
  output logic        dout,
  output logic [23:0] reg_spi_mux,
  output logic [23:0] reg_led
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // 2-FF synchronisers; spi_clk has one extra history stage for edge detection
  logic cs_s1, cs_s2;
  logic sclk_s1, sclk_s2, sclk_prev;
  logic mosi_s1, mosi_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_s1     <= 1'b0;
      cs_s2     <= 1'b0;
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_prev <= 1'b0;
      mosi_s1   <= 1'b0;
      mosi_s2   <= 1'b0;
    end else begin
      cs_s1     <= cs2;
      cs_s2     <= cs_s1;
      sclk_s1   <= spi_clk;
      sclk_s2   <= sclk_s1;
      sclk_prev <= sclk_s2;
      mosi_s1   <= spi_mosi;
      mosi_s2   <= mosi_s1;
    end
  end

  logic rise, fall;
  assign rise = sclk_s2 & ~sclk_prev;
  assign fall = ~sclk_s2 & sclk_prev;

  logic [5:0]  bit_cnt;
  logic [22:0] shift_in;   // only the last 23 bits are ever needed
  logic [23:0] shift_out;
  logic        wr_flag;
  logic [6:0]  addr;
  logic [23:0] rd_data;

  always_comb begin
    rd_data = 24'h0;
    case (addr)
      7'h01:   rd_data = reg_led;
      7'h02:   rd_data = reg_spi_mux;
      7'h03:   rd_data = status;
      7'h04:   rd_data = MAGIC;
      default: rd_data = 24'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // cs2 deassertion is checked first in every state so it beats a coincident edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!cs_s2) state_d = CMD;
      CMD: begin
        if (cs_s2)                           state_d = IDLE;
        else if (rise && bit_cnt == 6'd7)    state_d = DATA;
      end
      DATA: begin
        if (cs_s2)                           state_d = IDLE;
        else if (rise && bit_cnt == 6'd31)   state_d = DONE;
      end
      DONE: if (cs_s2) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= 6'd0;
      shift_in    <= 23'h0;
      shift_out   <= 24'h0;
      wr_flag     <= 1'b0;
      addr        <= 7'h0;
      dout        <= 1'b0;
      reg_led     <= 24'h0;
      reg_spi_mux <= 24'h0;
    end else if (cs_s2) begin
      // bus released: drop any partial frame, registers untouched
      bit_cnt   <= 6'd0;
      shift_in  <= 23'h0;
      shift_out <= 24'h0;
      dout      <= 1'b0;
    end else begin
      case (state_q)
        CMD: begin
          if (rise) begin
            shift_in <= {shift_in[21:0], mosi_s2};
            bit_cnt  <= bit_cnt + 6'd1;
            if (bit_cnt == 6'd7) begin
              wr_flag <= shift_in[6];
              addr    <= {shift_in[5:0], mosi_s2};
            end
          end
        end
        DATA: begin
          if (rise) begin
            shift_in <= {shift_in[21:0], mosi_s2};
            bit_cnt  <= bit_cnt + 6'd1;
            if (bit_cnt == 6'd31 && wr_flag) begin
              case (addr)
                7'h01:   reg_led     <= {shift_in, mosi_s2};
                7'h02:   reg_spi_mux <= {shift_in, mosi_s2};
                default: ;
              endcase
            end
          end else if (fall && !wr_flag) begin
            if (bit_cnt == 6'd8) begin
              shift_out <= rd_data;
              dout      <= rd_data[23];
            end else if (bit_cnt > 6'd8) begin
              shift_out <= {shift_out[22:0], 1'b0};
              dout      <= shift_out[22];
            end
          end
        end
        default: begin
          // IDLE and DONE: no edge processing, counter holds (saturates in DONE)
          dout <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb/tb_spi_reg_bank.sv - self-checking bench for spi_reg_bank
module tb_spi_reg_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs2;
  logic        spi_clk;
  logic        spi_mosi;
  logic [23:0] status;
  logic        dout;
  logic [23:0] reg_spi_mux;
  logic [23:0] reg_led;

  localparam logic [23:0] MAGIC = 24'hA5_0001;

  spi_reg_bank #(.MAGIC(MAGIC)) dut (
    .clk         (clk),
    .rst         (rst),
    .cs2         (cs2),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .status      (status),
    .dout        (dout),
    .reg_spi_mux (reg_spi_mux),
    .reg_led     (reg_led)
  );

  always #5 clk = ~clk;

  int   nvec = 0;
  int   nerr = 0;
  logic exp_q[$];
  logic [23:0] m_led = 24'h0;
  logic [23:0] m_mux = 24'h0;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model_read(input logic [6:0] a);
    case (a)
      7'h01:   return m_led;
      7'h02:   return m_mux;
      7'h03:   return status;
      7'h04:   return MAGIC;
      default: return 24'h0;
    endcase
  endfunction

  // One framed transaction of nbits; bits past 32 are sent as 1
  task automatic send_frame(input logic [31:0] frame, input int nbits);
    logic        wr;
    logic [23:0] rd;
    logic        e;
    wr = frame[31];
    rd = model_read(frame[30:24]);
    if (wr && nbits >= 32) begin
      if (frame[30:24] == 7'h01) m_led = frame[23:0];
      if (frame[30:24] == 7'h02) m_mux = frame[23:0];
    end
    for (int i = 0; i < nbits; i++)
      exp_q.push_back((!wr && i >= 8 && i < 32) ? rd[31-i] : 1'b0);
    @(negedge clk);
    cs2 = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 32) ? frame[31-i] : 1'b1;
      repeat (5) @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("dout_bit%0d", i), {23'h0, dout}, {23'h0, e});
      spi_clk = 1'b1;
      if (i == 31) begin
        repeat (4) @(negedge clk);
        check("led_after_bit31", reg_led, m_led);
        check("mux_after_bit31", reg_spi_mux, m_mux);
        @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
      end
      spi_clk = 1'b0;
    end
    repeat (5) @(negedge clk);
    cs2 = 1'b1;
    repeat (5) @(negedge clk);
    check("dout_idle", {23'h0, dout}, 24'h0);
  endtask

  initial begin
    rst = 1'b1; cs2 = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; status = 24'h00C0DE;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_led", reg_led, 24'h0);
    check("rst_mux", reg_spi_mux, 24'h0);
    check("rst_dout", {23'h0, dout}, 24'h0);

    send_frame(32'h81_5A5A5A, 32);
    check("led_5a", reg_led, 24'h5A5A5A);

    // reset in the middle of a frame
    cs2 = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      spi_mosi = 1'b1;
      repeat (5) @(negedge clk);
      spi_clk = 1'b1;
      repeat (5) @(negedge clk);
      spi_clk = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_led", reg_led, 24'h0);
    check("midrst_mux", reg_spi_mux, 24'h0);
    check("midrst_dout", {23'h0, dout}, 24'h0);
    rst = 1'b0;
    m_led = 24'h0;
    m_mux = 24'h0;
    repeat (3) @(negedge clk);
    cs2 = 1'b1;
    repeat (6) @(negedge clk);

    send_frame(32'h82_000004, 32);
    check("mux_4", reg_spi_mux, 24'h000004);
    check("led_unchanged", reg_led, 24'h0);

    send_frame(32'h04_000000, 32);   // MAGIC
    send_frame(32'h02_000000, 32);   // reg_spi_mux
    send_frame(32'h7F_000000, 32);   // unmapped

    // aborted write after 20 bits
    send_frame(32'h81_777777, 20);
    check("abort_led", reg_led, 24'h0);
    send_frame(32'h81_ABCDEF, 32);
    check("led_abcdef", reg_led, 24'hABCDEF);
    send_frame(32'h01_000000, 32);

    // overlength frame
    send_frame(32'h81_123456, 40);
    check("led_123456", reg_led, 24'h123456);

    // write to read-only addresses, then status readback
    send_frame(32'h83_FFFFFF, 32);
    send_frame(32'h84_FFFFFF, 32);
    check("ro_led", reg_led, 24'h123456);
    check("ro_mux", reg_spi_mux, 24'h000004);
    send_frame(32'h03_000000, 32);
    send_frame(32'h04_000000, 32);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
